// File: rtl/nios2e_ocimem_pkg.sv
// ---------------------------------------------------------------------------
// nios2e_ocimem_pkg
//
// Shared definitions for the on-chip debug monitor memory controller:
//   - FSM state encoding for the JTAG-side operation sequencer
//   - bit positions of the fields carried in the 38-bit jdo word
//   - the data pattern returned for out-of-range debug reads
//   - the CPU read-counter value at which RAM read data is valid
//   - a range-check helper for the 16-bit monitor address register
//
// Optional feature macro: OCIMEM_RDATA_REG_EN adds one more RAM output
// register, one more read-wait state and one more CPU read cycle.
// ---------------------------------------------------------------------------
package nios2e_ocimem_pkg;

    // jdo field positions
    localparam int JDO_ADDR_LSB = 2;
    localparam int JDO_ADDR_MSB = 17;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_DATA_MSB = 34;
    localparam int JDO_RDGO_BIT = 34;

    // Returned to the JTAG side for reads outside the monitor RAM
    localparam logic [31:0] OOR_PATTERN = 32'hDEADBEEF;

    // Value of the CPU read counter in the cycle the RAM output is valid.
    // The counter is 0 in the issue cycle.
`ifdef OCIMEM_RDATA_REG_EN
    localparam logic [1:0] CPU_RD_VALID_CNT = 2'd2;
`else
    localparam logic [1:0] CPU_RD_VALID_CNT = 2'd1;
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_CAP   = 3'd4,
        DONE     = 3'd5
`ifdef OCIMEM_RDATA_REG_EN
        ,
        RD_WAIT2 = 3'd6
`endif
    } ocimem_state_e;

    // The monitor address register is 16 bits wide; only addresses below
    // the RAM depth map onto real words.
    function automatic logic addr_in_range(input logic [15:0] addr,
                                           input int          depth);
        return (int'(addr) < depth);
    endfunction

endpackage

// File: rtl/nios2e_ocimem_ram.sv
// ---------------------------------------------------------------------------
// nios2e_ocimem_ram
//
// Single-port synchronous monitor RAM, DEPTH x 32, with byte enables.
// Read data appears one clock after a read is issued and is held until the
// next read (writes do not disturb it). With OCIMEM_RDATA_REG_EN defined a
// second output register adds one more clock of read latency.
//
// Ports:
//   clk    in   clock
//   en     in   access enable (read when we=0, write when we=1)
//   we     in   write enable
//   addr   in   AW-bit word address
//   wdata  in   32-bit write data
//   be     in   4-bit byte enables for writes
//   rdata  out  32-bit read data
//
// Contents are not reset.
// ---------------------------------------------------------------------------
module nios2e_ocimem_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                q <= mem[addr];
            end
        end
    end

`ifdef OCIMEM_RDATA_REG_EN
    logic [31:0] q_reg;

    // q only changes on reads, so this stage simply follows it one clock late
    always_ff @(posedge clk) begin
        q_reg <= q;
    end

    assign rdata = q_reg;
`else
    assign rdata = q;
`endif

endmodule

// File: rtl/nios2e_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// nios2e_ocimem_ctrl
//
// System-clock side of the debug monitor memory. Consumes decoded JTAG
// command strobes, runs address-load / write / read-next operations against
// the monitor RAM, and shares the RAM with a CPU Avalon-MM slave port.
// Debug accesses always win the RAM.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   jdo[37:0]                  JTAG data, only looked at on a strobe cycle
//   take_action_ocimem_a       pulse: load address (jdo[34] also starts a read)
//   take_action_ocimem_b       pulse: write jdo[34:3] at the monitor address
//   take_no_action_ocimem_a    pulse: read the word at the monitor address
//   MonDReg[31:0]              read data / last written data to JTAG
//   monitor_ready              last debug operation has completed
//   monitor_error              out-of-range access or dropped strobe since
//                              the last address load
//   avs_*                      CPU Avalon-MM slave (word addressed)
//
// Optional feature macro: OCIMEM_RDATA_REG_EN (registered RAM read data;
// debug reads take 4 cycles, CPU reads at least 3).
//
// Avalon handshake: a CPU transfer completes on the rising edge where
// avs_read or avs_write is high and avs_waitrequest is low; the master holds
// address/data/byteenable stable while waitrequest is high. For reads,
// avs_readdata is valid only in that completing cycle.
// ---------------------------------------------------------------------------
module nios2e_ocimem_ctrl
    import nios2e_ocimem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error,
    input  logic [AW-1:0] avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    input  logic [3:0]    avs_byteenable,
    output logic [31:0]   avs_readdata,
    output logic          avs_waitrequest
);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    ocimem_state_e state_q;
    ocimem_state_e state_d;

    logic [15:0] mon_a;        // MonAReg, full 16 bits kept for range checks
    logic [31:0] mon_d;        // MonDReg
    logic        ready_q;
    logic        err_q;
    logic        rd_oor;       // the read issued last was out of range
    logic [1:0]  cpu_rd_cnt;   // cycles the current CPU read has been granted
    logic        rst_done;     // low only until the first clock after reset

    // -----------------------------------------------------------------------
    // Decoded control (from the output process)
    // -----------------------------------------------------------------------
    logic dbg_load;
    logic dbg_wr_start;
    logic dbg_rd_start;
    logic drop;
    logic dbg_ram_sel;
    logic ram_dbg_we;
    logic ram_dbg_re;
    logic addr_inc;
    logic capture;
    logic set_ready;

    logic any_strobe;
    logic in_range;

    logic        cpu_grant;
    logic        cpu_rd_req;
    logic        cpu_we;
    logic        cpu_re;
    logic        cpu_rd_valid;

    logic        ram_en;
    logic        ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;

    // jdo bits outside the address/data fields carry nothing for this block
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[1:0]};

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b
                      | take_no_action_ocimem_a;
    assign in_range   = addr_in_range(mon_a, DEPTH);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    state_d = jdo[JDO_RDGO_BIT] ? RD_ISSUE : IDLE;
                end else if (take_action_ocimem_b) begin
                    state_d = WR;
                end else if (take_no_action_ocimem_a) begin
                    state_d = RD_ISSUE;
                end
            end
            WR:       state_d = DONE;
            RD_ISSUE: state_d = RD_WAIT;
`ifdef OCIMEM_RDATA_REG_EN
            RD_WAIT:  state_d = RD_WAIT2;
            RD_WAIT2: state_d = RD_CAP;
`else
            RD_WAIT:  state_d = RD_CAP;
`endif
            RD_CAP:   state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (control strobes for the datapath and RAM)
    // -----------------------------------------------------------------------
    always_comb begin
        dbg_load     = 1'b0;
        dbg_wr_start = 1'b0;
        dbg_rd_start = 1'b0;
        drop         = 1'b0;
        dbg_ram_sel  = 1'b0;
        ram_dbg_we   = 1'b0;
        ram_dbg_re   = 1'b0;
        addr_inc     = 1'b0;
        capture      = 1'b0;
        set_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                // Priority a > b > no_action; every strobe that loses is
                // reported as an error.
                dbg_load     = take_action_ocimem_a;
                dbg_wr_start = !take_action_ocimem_a && take_action_ocimem_b;
                dbg_rd_start = !take_action_ocimem_a && !take_action_ocimem_b
                             && take_no_action_ocimem_a;
                drop = (take_action_ocimem_a
                        && (take_action_ocimem_b || take_no_action_ocimem_a))
                    || (take_action_ocimem_b && take_no_action_ocimem_a);
            end
            WR: begin
                dbg_ram_sel = 1'b1;
                ram_dbg_we  = in_range;
                addr_inc    = 1'b1;
            end
            RD_ISSUE: begin
                dbg_ram_sel = 1'b1;
                ram_dbg_re  = in_range;
                addr_inc    = 1'b1;
            end
            RD_CAP: begin
                capture   = 1'b1;
                set_ready = 1'b1;
            end
            DONE: begin
                set_ready = 1'b1;
            end
            default: begin
            end
        endcase
        // Any strobe while an operation is in flight is lost
        if (state_q != IDLE) begin
            drop = any_strobe;
        end
    end

    // -----------------------------------------------------------------------
    // Debug datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_a    <= '0;
            mon_d    <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_oor   <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;

            if (dbg_load) begin
                mon_a   <= jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
                err_q   <= 1'b0;
                ready_q <= 1'b0;
            end
            if (dbg_wr_start) begin
                mon_d   <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                ready_q <= 1'b0;
            end
            if (dbg_rd_start) begin
                ready_q <= 1'b0;
            end
            if (ram_dbg_we == 1'b0 && state_q == WR) begin
                err_q <= 1'b1;
            end
            if (state_q == RD_ISSUE) begin
                rd_oor <= !in_range;
            end
            if (addr_inc) begin
                mon_a <= mon_a + 16'd1;
            end
            if (capture) begin
                mon_d <= rd_oor ? OOR_PATTERN : ram_rdata;
                if (rd_oor) begin
                    err_q <= 1'b1;
                end
            end
            if (set_ready) begin
                ready_q <= 1'b1;
            end
            // Last so that a dropped strobe beats the clear of an address load
            if (drop) begin
                err_q <= 1'b1;
            end
        end
    end

    assign MonDReg       = mon_d;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;

    // -----------------------------------------------------------------------
    // CPU port
    // The CPU only gets the RAM when the sequencer is idle and no strobe is
    // arriving. Losing the grant mid-read restarts the read from the issue
    // cycle, because a debug read may have replaced the RAM output.
    // -----------------------------------------------------------------------
    assign cpu_grant    = rst_done && (state_q == IDLE) && !any_strobe;
    assign cpu_rd_req   = avs_read && !avs_write;
    assign cpu_we       = cpu_grant && avs_write;
    assign cpu_re       = cpu_grant && cpu_rd_req && (cpu_rd_cnt == 2'd0);
    assign cpu_rd_valid = cpu_grant && cpu_rd_req
                        && (cpu_rd_cnt == CPU_RD_VALID_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rd_cnt <= '0;
        end else if (cpu_grant && cpu_rd_req) begin
            cpu_rd_cnt <= cpu_rd_valid ? 2'd0 : cpu_rd_cnt + 2'd1;
        end else begin
            cpu_rd_cnt <= '0;
        end
    end

    assign avs_waitrequest = !cpu_grant || (cpu_rd_req && !cpu_rd_valid);
    assign avs_readdata    = cpu_rd_valid ? ram_rdata : 32'd0;

    // -----------------------------------------------------------------------
    // RAM port mux
    // -----------------------------------------------------------------------
    assign ram_en    = ram_dbg_we || ram_dbg_re || cpu_we || cpu_re;
    assign ram_we    = ram_dbg_we || cpu_we;
    assign ram_addr  = dbg_ram_sel ? mon_a[AW-1:0] : avs_address;
    assign ram_wdata = dbg_ram_sel ? mon_d : avs_writedata;
    assign ram_be    = dbg_ram_sel ? 4'hF : avs_byteenable;

    nios2e_ocimem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .be    (ram_be),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_nios2e_ocimem_ctrl.sv
module tb_nios2e_ocimem_ctrl;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
`ifdef OCIMEM_RDATA_REG_EN
  localparam int DBG_RD_LAT = 4;
  localparam int CPU_RD_LAT = 3;
`else
  localparam int DBG_RD_LAT = 3;
  localparam int CPU_RD_LAT = 2;
`endif
  localparam int DBG_WR_LAT = 2;

  localparam int OP_LOAD  = 0;
  localparam int OP_WRITE = 1;
  localparam int OP_READ  = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [37:0]   jdo = '0;
  logic          ta_a = 1'b0;
  logic          ta_b = 1'b0;
  logic          tn_a = 1'b0;
  logic [31:0]   mon_dreg;
  logic          mon_ready;
  logic          mon_error;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [3:0]    avs_byteenable = '0;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;

  nios2e_ocimem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tn_a),
    .MonDReg                 (mon_dreg),
    .monitor_ready           (mon_ready),
    .monitor_error           (mon_error),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m_mem [DEPTH];
  logic [15:0] m_a;
  logic [31:0] m_d;
  logic        m_err;
  logic        m_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_d = '0; m_err = 1'b0; m_rdy = 1'b0;
  endtask

  task automatic model_read();
    m_rdy = 1'b1;
    if (int'(m_a) < DEPTH) m_d = m_mem[m_a];
    else begin
      m_d = 32'hDEADBEEF;
      m_err = 1'b1;
    end
    m_a = m_a + 16'd1;
  endtask

  task automatic model_apply(input int op, input logic [15:0] addr, input logic go, input logic [31:0] data);
    case (op)
      OP_LOAD: begin
        m_a = addr; m_err = 1'b0; m_rdy = 1'b0;
        if (go) model_read();
      end
      OP_WRITE: begin
        m_rdy = 1'b1; m_d = data;
        if (int'(m_a) < DEPTH) m_mem[m_a] = data;
        else m_err = 1'b1;
        m_a = m_a + 16'd1;
      end
      default: model_read();
    endcase
  endtask

  function automatic int exp_lat(input int op, input logic go);
    if (op == OP_WRITE) return DBG_WR_LAT;
    if (op == OP_LOAD && !go) return 0;
    return DBG_RD_LAT;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulses one strobe, then waits for monitor_ready (bounded). lat is the
  // number of clocks from the strobe edge to ready, 0 if it never came.
  task automatic dbg_op(input int op, input logic [15:0] addr, input logic go,
                        input logic [31:0] data, output int lat);
    jdo = 38'({$urandom(), $urandom()});
    case (op)
      OP_LOAD:  begin jdo[17:2] = addr; jdo[34] = go; ta_a = 1'b1; end
      OP_WRITE: begin jdo[34:3] = data; ta_b = 1'b1; end
      default:  tn_a = 1'b1;
    endcase
    tick();
    ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0;
    jdo = 38'({$urandom(), $urandom()});
    lat = 0;
    if (!(op == OP_LOAD && !go)) begin
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (mon_ready) begin
          lat = i;
          break;
        end
      end
    end
    tick();  // let the sequencer return to idle
  endtask

  task automatic dbg_check(input int op, input logic [15:0] addr, input logic go,
                           input logic [31:0] data, input string tag);
    int lat;
    dbg_op(op, addr, go, data, lat);
    model_apply(op, addr, go, data);
    check({tag, "_dreg"}, mon_dreg, m_d);
    check({tag, "_err"}, mon_error, m_err);
    check({tag, "_rdy"}, mon_ready, m_rdy);
    check({tag, "_lat"}, lat, exp_lat(op, go));
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    logic done;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 40) begin
      #1; n++;
      done = !avs_waitrequest;
      @(posedge clk); #1;
    end
    avs_write = 1'b0;
    if (!done) check("cpu_write_timeout", 32'(n), 32'd0);
    else for (int b = 0; b < 4; b++) if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input string tag);
    int n;
    logic done;
    logic [31:0] got;
    avs_address = a; avs_read = 1'b1;
    exp_q.push_back(m_mem[a]);
    n = 0; done = 1'b0; got = '0;
    while (!done && n < 40) begin
      #1; n++;
      if (!avs_waitrequest) begin
        done = 1'b1;
        got = avs_readdata;
      end
      @(posedge clk); #1;
    end
    avs_read = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_data"}, got, exp_q.pop_front());
    check({tag, "_lat"}, n, CPU_RD_LAT);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          op;
    logic [15:0] addr;
    logic        go;
    logic [31:0] data;
    logic        chk_d;
    logic [31:0] exp_d;
    logic        exp_err;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int lat, n;
    logic done, rdy_seen;
    logic [31:0] got, keep;

    vecs[0]  = '{OP_LOAD,  16'd0,     1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{OP_WRITE, 16'd0,     1'b0, 32'h0BADF00D, 1'b1, 32'h0BADF00D, 1'b0, 1'b1};
    vecs[2]  = '{OP_LOAD,  16'd5,     1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{OP_WRITE, 16'd0,     1'b0, 32'h12345678, 1'b1, 32'h12345678, 1'b0, 1'b1};
    vecs[4]  = '{OP_WRITE, 16'd0,     1'b0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1};
    vecs[5]  = '{OP_LOAD,  16'd5,     1'b1, 32'h0,        1'b1, 32'h12345678, 1'b0, 1'b1};
    vecs[6]  = '{OP_READ,  16'd0,     1'b0, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b1};
    vecs[7]  = '{OP_LOAD,  16'd255,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{OP_WRITE, 16'd0,     1'b0, 32'hAAAA5555, 1'b1, 32'hAAAA5555, 1'b0, 1'b1};
    vecs[9]  = '{OP_WRITE, 16'd0,     1'b0, 32'hBBBB6666, 1'b1, 32'hBBBB6666, 1'b1, 1'b1};
    vecs[10] = '{OP_LOAD,  16'd0,     1'b1, 32'h0,        1'b1, 32'h0BADF00D, 1'b0, 1'b1};
    vecs[11] = '{OP_LOAD,  16'd255,   1'b1, 32'h0,        1'b1, 32'hAAAA5555, 1'b0, 1'b1};
    vecs[12] = '{OP_READ,  16'd0,     1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[13] = '{OP_LOAD,  16'hFFFF,  1'b1, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[14] = '{OP_READ,  16'd0,     1'b0, 32'h0,        1'b1, 32'h0BADF00D, 1'b1, 1'b1};

    // ---------------- reset state ----------------
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dreg", mon_dreg, 32'h0);
    check("rst_ready", mon_ready, 1'b0);
    check("rst_error", mon_error, 1'b0);
    check("rst_waitreq", avs_waitrequest, 1'b1);
    check("rst_rdata", avs_readdata, 32'h0);
    reset_n = 1'b1;
    #1;
    check("rst_release_waitreq", avs_waitrequest, 1'b1);
    tick();
    check("post_rst_waitreq", avs_waitrequest, 1'b0);

    // Fill the RAM from the CPU side so every word is known
    for (int i = 0; i < DEPTH; i++) cpu_write(AW'(i), $urandom(), 4'hF);

    // ---------------- table-driven debug sequence ----------------
    for (int i = 0; i < 15; i++) begin
      dbg_op(vecs[i].op, vecs[i].addr, vecs[i].go, vecs[i].data, lat);
      model_apply(vecs[i].op, vecs[i].addr, vecs[i].go, vecs[i].data);
      if (vecs[i].chk_d) check($sformatf("vec%0d_dreg", i), mon_dreg, vecs[i].exp_d);
      check($sformatf("vec%0d_err", i), mon_error, vecs[i].exp_err);
      check($sformatf("vec%0d_rdy", i), mon_ready, vecs[i].exp_rdy);
      check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].op, vecs[i].go));
    end
    cpu_read(8'd255, "cpu_word255");
    cpu_read(8'd0, "cpu_word0");

    // ---------------- CPU byte enables ----------------
    cpu_write(8'd3, 32'h0, 4'hF);
    cpu_write(8'd3, 32'hFFFFFFFF, 4'b0101);
    check("be_model", m_mem[3], 32'h00FF00FF);
    cpu_read(8'd3, "cpu_be_word3");

    // ---------------- CPU read raised together with a debug strobe ----------------
    dbg_check(OP_LOAD, 16'd9, 1'b0, 32'h0, "h3_load");
    avs_address = 8'd3; avs_read = 1'b1;
    exp_q.push_back(m_mem[3]);
    jdo = '0; jdo[34:3] = 32'h5A5A0009; ta_b = 1'b1;
    #1;
    check("h3_wait_on_strobe", avs_waitrequest, 1'b1);
    @(posedge clk); #1;
    ta_b = 1'b0;
    model_apply(OP_WRITE, 16'd0, 1'b0, 32'h5A5A0009);
    n = 1; done = 1'b0; got = '0; rdy_seen = 1'b0;
    while (!done && n < 40) begin
      #1; n++;
      if (!avs_waitrequest) begin
        done = 1'b1; got = avs_readdata; rdy_seen = mon_ready;
      end
      @(posedge clk); #1;
    end
    avs_read = 1'b0;
    check("h3_done", done, 1'b1);
    check("h3_data", got, exp_q.pop_front());
    check("h3_lat", n, 3 + CPU_RD_LAT);
    check("h3_dbg_done_first", rdy_seen, 1'b1);
    dbg_check(OP_LOAD, 16'd9, 1'b1, 32'h0, "h3_verify");

    // ---------------- simultaneous address load and write ----------------
    jdo = '0; jdo[17:2] = 16'd7; ta_a = 1'b1; ta_b = 1'b1;
    tick();
    ta_a = 1'b0; ta_b = 1'b0;
    m_a = 16'd7; m_rdy = 1'b0; m_err = 1'b1;
    check("sim_err", mon_error, 1'b1);
    check("sim_rdy", mon_ready, 1'b0);
    repeat (4) tick();
    check("sim_no_write_rdy", mon_ready, 1'b0);
    dbg_check(OP_READ, 16'd0, 1'b0, 32'h0, "sim_read7");

    // ---------------- strobe dropped while a read is in RD_WAIT ----------------
    dbg_check(OP_LOAD, 16'd20, 1'b0, 32'h0, "rw_load");
    tn_a = 1'b1;
    tick();                  // strobe edge: RD_ISSUE next
    tn_a = 1'b0;
    tick();                  // now in RD_WAIT
    jdo = '0; jdo[34:3] = 32'h11111111; ta_b = 1'b1;
    tick();
    ta_b = 1'b0;
    lat = 0;
    for (int i = 3; i <= 20; i++) begin
      tick();
      if (mon_ready) begin
        lat = i;
        break;
      end
    end
    tick();
    model_read();
    m_err = 1'b1;
    check("rw_dreg", mon_dreg, m_d);
    check("rw_err", mon_error, 1'b1);
    check("rw_lat", lat, DBG_RD_LAT);
    dbg_check(OP_READ, 16'd0, 1'b0, 32'h0, "rw_next_unwritten");

    // ---------------- reset in the middle of a read ----------------
    dbg_check(OP_LOAD, 16'd30, 1'b0, 32'h0, "rr_load");
    tn_a = 1'b1;
    tick();
    tn_a = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("rr_dreg", mon_dreg, 32'h0);
    check("rr_rdy", mon_ready, 1'b0);
    check("rr_err", mon_error, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    model_reset();
    tick();
    dbg_check(OP_LOAD, 16'd30, 1'b1, 32'h0, "rr_word30");

    // ---------------- reset in the middle of a write ----------------
    dbg_check(OP_LOAD, 16'd31, 1'b0, 32'h0, "rw2_load");
    keep = m_mem[31];
    jdo = '0; jdo[34:3] = ~keep; ta_b = 1'b1;
    tick();                  // in WR now
    ta_b = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    model_reset();
    tick();
    dbg_check(OP_LOAD, 16'd31, 1'b1, 32'h0, "rw2_word31");
    check("rw2_unchanged", mon_dreg, keep);

    // ---------------- randomized debug operations ----------------
    for (int i = 0; i < 150; i++) begin
      int op;
      logic [15:0] a;
      op = $urandom_range(0, 2);
      a = ($urandom_range(0, 5) == 0) ? 16'($urandom()) : 16'($urandom_range(0, DEPTH + 2));
      dbg_check(op, a, 1'($urandom()), $urandom(), $sformatf("rnd%0d", i));
    end

    // ---------------- randomized CPU operations ----------------
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 0) cpu_write(a, $urandom(), 4'($urandom()));
      else cpu_read(a, $sformatf("cpu_rnd%0d", i));
    end
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
